uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM states and frame timing defaults shared by the
// UART transmit arbiter and its round-robin picker.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int FRAME_TICKS_DEF = 11;
   localparam int GAP_TICKS_DEF   = 1;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// uart_tx_rr_pick: combinational round-robin selection, searching
// from the index after the last grant and wrapping to 0.
module uart_tx_rr_pick
   import uart_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   index
);

   logic [IW-1:0] cand;

   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter core among NREQ
// requesters, one frame per grant, paced by baud_wire edges.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NREQ        = 4,
   parameter  int FRAME_TICKS = FRAME_TICKS_DEF,
   parameter  int GAP_TICKS   = GAP_TICKS_DEF,
   localparam int IW          = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] req_data,
   input  logic [NREQ-1:0]   req_p_sel,
   output logic [NREQ-1:0]   ack,
   output logic [IW-1:0]     owner,
   output logic              busy,
   input  logic              baud_wire,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              tx_p_sel
);

   localparam int CW = $clog2(FRAME_TICKS + 1);
   localparam logic [CW-1:0] FRAME_END = CW'(FRAME_TICKS);
   localparam logic [CW-1:0] GAP_END   = CW'(GAP_TICKS);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic          baud_q, tick, grant;
   logic          pick_valid;
   logic [IW-1:0] pick_idx;

   uart_tx_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .last  (owner),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // baud_q resets high so a high baud_wire at release is not an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) baud_q <= 1'b1;
      else       baud_q <= baud_wire;
   end

   assign tick    = baud_wire & ~baud_q;
   assign cnt_inc = cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               grant     = 1'b1;
               state_nxt = SEND;
               cnt_nxt   = '0;
            end
         end
         SEND: begin
            if (tick) begin
               if (cnt_inc == FRAME_END) begin
                  state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (cnt_inc == GAP_END) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack      <= '0;
         owner    <= IW'(NREQ - 1);
         tx_data  <= '0;
         tx_p_sel <= 1'b0;
         tx_start <= 1'b0;
      end else begin
         ack <= '0;
         if (grant) begin
            ack      <= ONE << pick_idx;
            owner    <= pick_idx;
            tx_data  <= req_data[{pick_idx, 3'b000} +: 8];
            tx_p_sel <= req_p_sel[pick_idx];
            tx_start <= 1'b1;
         end else if (state == SEND && tick) begin
            tx_start <= 1'b0;
         end
      end
   end

endmodule
